leaf_wb_ctrl: RTL and testbench



---
 rtl/leaf_wb_ctrl_pkg.sv | 12 +
 rtl/leaf_rst_seq.sv | 40 ++++
 rtl/leaf_wb_ctrl.sv | 96 +++++++++
 tb/tb_leaf_wb_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/leaf_wb_ctrl_pkg.sv
// leaf_wb_ctrl_pkg: register offsets, CTRL bit indices and FSM state types for leaf_wb_ctrl
package leaf_wb_ctrl_pkg;
  localparam logic [3:0] CTRL_OFS    = 4'h0;
  localparam logic [3:0] DIV_OFS     = 4'h4;
  localparam logic [3:0] STATUS_OFS  = 4'h8;
  localparam logic [3:0] SCRATCH_OFS = 4'hC;
  localparam int CTRL_RUN  = 0;
  localparam int CTRL_UART = 1;
  localparam int CTRL_IRQ  = 2;
  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;
  typedef enum logic [1:0] {SEQ_HOLD, SEQ_COUNT, SEQ_RUN} seq_state_t;
endpackage

// File: rtl/leaf_rst_seq.sv
// leaf_rst_seq: holds core reset until core_run has been high for RST_HOLD_CYCLES cycles
module leaf_rst_seq
  import leaf_wb_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic core_run,
  output logic core_rst_o,
  output logic seq_busy
);
  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);
  seq_state_t state, state_d;
  logic [7:0] cnt, cnt_d;
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    case (state)
      SEQ_HOLD:  state_d = core_run ? SEQ_COUNT : SEQ_HOLD;
      SEQ_COUNT: begin
        state_d = !core_run ? SEQ_HOLD : (cnt == HOLD_LAST) ? SEQ_RUN : SEQ_COUNT;
        cnt_d   = (core_run && cnt != HOLD_LAST) ? cnt + 8'd1 : '0;
      end
      SEQ_RUN:   state_d = core_run ? SEQ_RUN : SEQ_HOLD;
      default:   state_d = SEQ_HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEQ_HOLD;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end
  assign core_rst_o = state != SEQ_RUN;
  assign seq_busy   = state == SEQ_COUNT;
endmodule

// File: rtl/leaf_wb_ctrl.sv
// leaf_wb_ctrl: Wishbone control slave for leaf_chip (core reset, UART config, tx start-bit count); irq via LEAF_WB_CTRL_IRQ_EN
module leaf_wb_ctrl
  import leaf_wb_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE       = 32'h3000_0000,
  parameter int          RST_HOLD_CYCLES = 16,
  parameter int          DIV_W           = 16,
  parameter int          DIV_RESET       = 434
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             core_rst_o,
  output logic             uart_en_o,
  output logic [DIV_W-1:0] uart_div_o,
  input  logic             tx_i,
  output logic             irq_o
);
`ifdef LEAF_WB_CTRL_IRQ_EN
  localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
  localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif
  bus_state_t bus_q, bus_d;
  logic [2:0] ctrl, ctrl_nx, ctrl_wm;
  logic [DIV_W-1:0] div;
  logic [31:0] scratch, bmask, rdata, dat_q;
  logic [15:0] sb_cnt;
  logic [3:0] ofs;
  logic tx_q, tx_pend, tx_fall, go, wr, st_wr, seq_busy;
  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];
  assign go      = bus_q == BUS_IDLE && wbs_cyc_i && wbs_stb_i && wbs_adr_i[31:4] == ADDR_BASE[31:4];
  assign wr      = go && wbs_we_i;
  assign ofs     = {wbs_adr_i[3:2], 2'b00};
  assign st_wr   = wr && ofs == STATUS_OFS;
  assign bmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign ctrl_wm = wbs_sel_i[0] ? CTRL_WMASK : 3'b000;
  assign ctrl_nx = (wr && ofs == CTRL_OFS) ? (ctrl & ~ctrl_wm) | (wbs_dat_i[2:0] & ctrl_wm) : ctrl;
  assign tx_fall = tx_q && !tx_i && !core_rst_o;
  always_comb begin
    bus_d = go ? BUS_ACK : BUS_IDLE;
    rdata = ofs == CTRL_OFS   ? {29'b0, ctrl} :
            ofs == DIV_OFS    ? 32'(div) :
            ofs == STATUS_OFS ? {sb_cnt, 13'b0, tx_pend, seq_busy, core_rst_o} : scratch;
  end
  // Sequencer sees the post-write core_run so COUNT starts on the write-ack edge
  leaf_rst_seq #(.RST_HOLD_CYCLES(RST_HOLD_CYCLES)) u_seq (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .core_run   (ctrl_nx[CTRL_RUN]),
    .core_rst_o (core_rst_o),
    .seq_busy   (seq_busy)
  );
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bus_q   <= BUS_IDLE;
      dat_q   <= '0;
      ctrl    <= '0;
      div     <= DIV_W'(DIV_RESET);
      scratch <= '0;
      tx_q    <= 1'b0;
      sb_cnt  <= '0;
      tx_pend <= 1'b0;
    end else begin
      bus_q   <= bus_d;
      dat_q   <= go ? rdata : '0;
      ctrl    <= ctrl_nx;
      if (wr && ofs == DIV_OFS)
        div <= (div & ~bmask[DIV_W-1:0]) | (wbs_dat_i[DIV_W-1:0] & bmask[DIV_W-1:0]);
      if (wr && ofs == SCRATCH_OFS)
        scratch <= (scratch & ~bmask) | (wbs_dat_i & bmask);
      tx_q    <= tx_i;
      sb_cnt  <= st_wr ? '0 : (tx_fall && sb_cnt != 16'hFFFF) ? sb_cnt + 16'd1 : sb_cnt;
      tx_pend <= tx_fall ? 1'b1 : (st_wr && wbs_sel_i[0] && wbs_dat_i[2]) ? 1'b0 : tx_pend;
    end
  end
`ifdef LEAF_WB_CTRL_IRQ_EN
  logic irq_q;
  always_ff @(posedge wb_clk_i) irq_q <= wb_rst_i ? 1'b0 : tx_pend && ctrl[CTRL_IRQ];
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif
  assign wbs_ack_o  = bus_q == BUS_ACK;
  assign wbs_dat_o  = dat_q;
  assign uart_en_o  = ctrl[CTRL_UART];
  assign uart_div_o = div;
endmodule

// File: tb/tb_leaf_wb_ctrl.sv
// tb_leaf_wb_ctrl: directed self-checking bench for leaf_wb_ctrl
module tb_leaf_wb_ctrl;
  logic wb_clk_i = 0, wb_rst_i = 1, cyc = 0, stb = 0, we = 0, tx = 1;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, wdat = 0, rdat, rd;
  logic ack, core_rst, uart_en, irq, got;
  logic [15:0] div;
  int checks = 0, failures = 0, n, hi;
  always #5 wb_clk_i = ~wb_clk_i;
  leaf_wb_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat), .core_rst_o(core_rst), .uart_en_o(uart_en),
    .uart_div_o(div), .tx_i(tx), .irq_o(irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge wb_clk_i);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s; n = 0;
    do begin @(negedge wb_clk_i); n++; end while (!ack && n < 8);
    rd = rdat; got = ack;
    cyc = 0; stb = 0; we = 0;
  endtask
  task automatic pulse();
    @(negedge wb_clk_i) tx = 0;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i) tx = 1;
    @(negedge wb_clk_i);
  endtask
  initial begin
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i) wb_rst_i = 0;
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_uart_en", uart_en, 0);
    chk("rst_div", div, 434);
    chk("rst_irq", irq, 0);
    wb(0, 32'h3000_0004, 0, 4'hF);
    chk("div_rd_lat", n, 1);
    chk("div_rd", rd, 434);
    @(negedge wb_clk_i);
    chk("ack_one_cycle", ack, 0);
    chk("ack_idle_dat", rdat, 0);
    wb(0, 32'h3000_0008, 0, 4'hF);
    chk("status_rst", rd, 32'h1);
    wb(1, 32'h3000_0000, 32'h1, 4'hF);
    chk("seq_k0", core_rst, 1);
    wb(0, 32'h3000_0008, 0, 4'hF);
    chk("status_busy", rd, 32'h3);
    repeat (13) @(negedge wb_clk_i);
    chk("seq_k15", core_rst, 1);
    @(negedge wb_clk_i);
    chk("seq_k16", core_rst, 0);
    wb(0, 32'h3000_0008, 0, 4'hF);
    chk("status_run", rd, 32'h0);
    wb(1, 32'h3000_0000, 32'h0, 4'hF);
    chk("stop_rst", core_rst, 1);
    wb(1, 32'h3000_0000, 32'h1, 4'hF);
    hi = 0;
    repeat (4) @(negedge wb_clk_i) hi += int'(core_rst);
    wb(1, 32'h3000_0000, 32'h0, 4'hF);
    chk("abort_held", hi + int'(core_rst), 5);
    wb(1, 32'h3000_0000, 32'h1, 4'hF);
    repeat (15) @(negedge wb_clk_i);
    chk("restart_k15", core_rst, 1);
    @(negedge wb_clk_i);
    chk("restart_k16", core_rst, 0);
    wb(1, 32'h3000_0000, 32'h3, 4'hF);
    chk("rewrite_run", core_rst, 0);
    chk("uart_en", uart_en, 1);
    wb(1, 32'h3000_0004, 32'h0000_1234, 4'h1);
    chk("div_byte0", div, 16'h0134);
    wb(1, 32'h3000_0004, 32'hFFFF_5678, 4'hF);
    wb(0, 32'h3000_0004, 0, 4'hF);
    chk("div_upper_zero", rd, 32'h0000_5678);
    wb(1, 32'h3000_000C, 32'h1122_3344, 4'hF);
    wb(1, 32'h3000_000C, 32'hAABB_CCDD, 4'b0101);
    wb(0, 32'h3000_000F, 0, 4'hF);
    chk("scratch_sel", rd, 32'h11BB_33DD);
    wb(0, 32'h3000_0010, 0, 4'hF);
    chk("oow_noack", got, 0);
    chk("oow_wait", n, 8);
    wb(1, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF);
    wb(0, 32'h3000_0000, 0, 4'hF);
`ifdef LEAF_WB_CTRL_IRQ_EN
    chk("ctrl_rd", rd, 32'h7);
`else
    chk("ctrl_rd", rd, 32'h3);
`endif
    repeat (3) pulse();
    wb(0, 32'h3000_0008, 0, 4'hF);
    chk("status_tx3", rd, 32'h0003_0004);
`ifdef LEAF_WB_CTRL_IRQ_EN
    chk("irq_set", irq, 1);
`else
    chk("irq_set", irq, 0);
`endif
    wb(1, 32'h3000_0008, 32'h4, 4'h1);
    @(negedge wb_clk_i);
    chk("irq_w1c", irq, 0);
    wb(0, 32'h3000_0008, 0, 4'hF);
    chk("status_w1c", rd, 32'h0);
    pulse();
    wb(1, 32'h3000_0008, 32'h0, 4'hF);
    wb(0, 32'h3000_0008, 0, 4'hF);
    chk("status_cnt_clr", rd, 32'h0000_0004);
    wb(1, 32'h3000_0000, 32'h0, 4'hF);
    wb(1, 32'h3000_0000, 32'h1, 4'hF);
    @(negedge wb_clk_i);
    cyc = 1; stb = 1; we = 0; adr = 32'h3000_0004; sel = 4'hF;
    @(negedge wb_clk_i);
    chk("pre_rst_ack", ack, 1);
    chk("pre_rst_dat", rdat, 32'h5678);
    wb_rst_i = 1; cyc = 0; stb = 0;
    @(negedge wb_clk_i);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_dat", rdat, 0);
    chk("mid_rst_core", core_rst, 1);
    chk("mid_rst_div", div, 434);
    chk("mid_rst_uart", uart_en, 0);
    wb_rst_i = 0;
    wb(0, 32'h3000_0008, 0, 4'hF);
    chk("post_rst_status", rd, 32'h1);
    repeat (20) @(negedge wb_clk_i);
    chk("post_rst_hold", core_rst, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
